// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encodings, SPI mode constants and clog2 helper
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } spi_state_e;

  // {CPOL, CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - one-cycle tick every CLK_DIV clocks while run is high
// Ports: clk, rst_n (async, active-low), run (counter clears when low), tick (pulse).
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int CW = clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!run) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_core.sv
// rtl/spi_master_core.sv - SPI initiator, one BITNUM-bit MSB-first word per transfer, all CPOL/CPHA modes
// Ports: clk, rst_n (async, active-low), en (abort on low);
//   CPOL/CPHA/data_in latched on start; busy, data_out, data_ready (1-cycle pulse);
//   CS (active low), DCLK, MOSI driven; MISO sampled (already clk-synchronous).
module spi_master_core
  import spi_pkg::*;
#(
  parameter int BITNUM  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              CPOL,
  input  logic              CPHA,
  input  logic              start,
  input  logic [BITNUM-1:0] data_in,
  output logic              busy,
  output logic [BITNUM-1:0] data_out,
  output logic              data_ready,
  output logic              CS,
  output logic              DCLK,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int EW = clog2(2 * BITNUM + 1);
  localparam logic [EW-1:0] EDGE_LAST    = EW'(2 * BITNUM);
  localparam logic [EW-1:0] EDGE_TX_LAST = EW'(2 * BITNUM - 2);
  localparam logic [EW-1:0] EDGE_THREE   = EW'(3);

  spi_state_e        state_q, state_d;
  logic [BITNUM-1:0] tx_shift_q, tx_shift_d;
  logic [BITNUM-1:0] rx_shift_q, rx_shift_d;
  logic [BITNUM-1:0] data_out_q, data_out_d;
  logic [EW-1:0]     edge_cnt_q, edge_cnt_d;
  logic [EW-1:0]     edge_next;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              cs_q, cs_d;
  logic              dclk_q, dclk_d;
  logic              busy_q, busy_d;
  logic              data_ready_q, data_ready_d;
  logic              div_run;
  logic              div_tick;
  logic              sample_edge;
  logic              shift_edge;

  // One divider paces SETUP, every XFER half-period and HOLD, so CS stays
  // low for exactly CLK_DIV*(2*BITNUM+2) cycles.
  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (div_run),
    .tick  (div_tick)
  );

  always_comb begin
    state_d      = state_q;
    tx_shift_d   = tx_shift_q;
    rx_shift_d   = rx_shift_q;
    data_out_d   = data_out_q;
    edge_cnt_d   = edge_cnt_q;
    cpol_d       = cpol_q;
    cpha_d       = cpha_q;
    cs_d         = cs_q;
    dclk_d       = dclk_q;
    busy_d       = busy_q;
    data_ready_d = 1'b0;
    edge_next    = edge_cnt_q;
    sample_edge  = 1'b0;
    shift_edge   = 1'b0;
    div_run      = (state_q == ST_SETUP) || (state_q == ST_XFER) || (state_q == ST_HOLD);

    if (!en && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      cs_d       = 1'b1;
      dclk_d     = cpol_q;
      busy_d     = 1'b0;
      edge_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          dclk_d = CPOL;
          if (start && en) begin
            tx_shift_d = data_in;
            rx_shift_d = '0;
            cpol_d     = CPOL;
            cpha_d     = CPHA;
            cs_d       = 1'b0;
            busy_d     = 1'b1;
            edge_cnt_d = '0;
            state_d    = ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (div_tick) begin
            state_d = ST_XFER;
          end
        end
        ST_XFER: begin
          if (div_tick) begin
            edge_next  = (edge_cnt_q == EDGE_LAST) ? edge_cnt_q : edge_cnt_q + 1'b1;
            edge_cnt_d = edge_next;
            dclk_d     = ~dclk_q;
            // Edge numbering starts at 1, so bit 0 set means an odd edge.
            // With CPHA=1 the MSB is already on MOSI, so edge 1 never shifts.
            if (cpha_q) begin
              sample_edge = ~edge_next[0];
              shift_edge  = edge_next[0] && (edge_next >= EDGE_THREE);
            end else begin
              sample_edge = edge_next[0];
              shift_edge  = ~edge_next[0] && (edge_next <= EDGE_TX_LAST);
            end
            if (sample_edge) begin
              rx_shift_d = {rx_shift_q[BITNUM-2:0], MISO};
            end
            if (shift_edge) begin
              tx_shift_d = {tx_shift_q[BITNUM-2:0], 1'b0};
            end
            if (edge_next == EDGE_LAST) begin
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (div_tick) begin
            cs_d    = 1'b1;
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          data_out_d   = rx_shift_q;
          data_ready_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      tx_shift_q   <= '0;
      rx_shift_q   <= '0;
      data_out_q   <= '0;
      edge_cnt_q   <= '0;
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      cs_q         <= 1'b1;
      dclk_q       <= 1'b0;
      busy_q       <= 1'b0;
      data_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_shift_q   <= tx_shift_d;
      rx_shift_q   <= rx_shift_d;
      data_out_q   <= data_out_d;
      edge_cnt_q   <= edge_cnt_d;
      cpol_q       <= cpol_d;
      cpha_q       <= cpha_d;
      cs_q         <= cs_d;
      dclk_q       <= dclk_d;
      busy_q       <= busy_d;
      data_ready_q <= data_ready_d;
    end
  end

  assign busy       = busy_q;
  assign data_out   = data_out_q;
  assign data_ready = data_ready_q;
  assign CS         = cs_q;
  assign DCLK       = dclk_q;
  assign MOSI       = tx_shift_q[BITNUM-1];

endmodule

// File: tb/tb_spi_master_core.sv
// tb/tb_spi_master_core.sv - self-checking bench for spi_master_core with a behavioural SPI responder
module tb_spi_master_core;
  import spi_pkg::*;

  localparam int B      = 8;
  localparam int DIV    = 4;
  localparam int CS_LOW = DIV * (2 * B + 2);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         CPOL = 1'b0;
  logic         CPHA = 1'b0;
  logic         start = 1'b0;
  logic [B-1:0] data_in = '0;
  logic         busy;
  logic [B-1:0] data_out;
  logic         data_ready;
  logic         CS;
  logic         DCLK;
  logic         MOSI;
  logic         MISO;

  int checks = 0;
  int errors = 0;

  // Responder / observer state
  logic [7:0] resp_word = 8'h00;
  bit         loopback = 1'b0;
  bit         cur_cpha = 1'b0;
  logic       miso_r = 1'b0;
  int         edge_k = 0;
  int         cs_low_cnt = 0;
  int         ready_cnt = 0;
  int         mosi_bad = 0;
  logic [7:0] mosi_word = 8'h00;
  logic       dclk_prev = 1'b0;
  logic       cs_prev = 1'b1;
  logic       mosi_prev = 1'b0;

  assign MISO = loopback ? MOSI : miso_r;

  spi_master_core #(.BITNUM(B), .CLK_DIV(DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .CPOL       (CPOL),
    .CPHA       (CPHA),
    .start      (start),
    .data_in    (data_in),
    .busy       (busy),
    .data_out   (data_out),
    .data_ready (data_ready),
    .CS         (CS),
    .DCLK       (DCLK),
    .MOSI       (MOSI),
    .MISO       (MISO)
  );

  always #5 clk = ~clk;

  // SPI responder: captures MOSI on sampling edges, launches its next MISO
  // bit on the opposite edges, counts edges and CS-low cycles.
  always @(negedge clk) begin : monitor
    int k;
    int nb;
    if (CS === 1'b0) begin
      if (cs_prev === 1'b1) begin
        edge_k     <= 0;
        cs_low_cnt <= 1;
        mosi_word  <= 8'h00;
        mosi_bad   <= 0;
        miso_r     <= resp_word[7];
      end else begin
        cs_low_cnt <= cs_low_cnt + 1;
        if (DCLK !== dclk_prev) begin
          k = edge_k + 1;
          edge_k <= k;
          if (((k % 2) == 0) == cur_cpha) begin
            mosi_word <= {mosi_word[6:0], MOSI};
            if (MOSI !== mosi_prev) mosi_bad <= mosi_bad + 1;
          end else begin
            nb = cur_cpha ? (k - 1) / 2 : k / 2;
            if (nb <= 7) miso_r <= resp_word[7-nb];
          end
        end
      end
    end
    dclk_prev <= DCLK;
    cs_prev   <= CS;
    mosi_prev <= MOSI;
    if (data_ready === 1'b1) ready_cnt <= ready_cnt + 1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag, output bit got);
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (data_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s ready_timeout: data_ready=0 after 400 cycles, required 1", tag);
    end
  endtask

  task automatic wait_edge(input string tag, input int k, output bit got);
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (CS === 1'b0 && edge_k == k) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s edge_timeout: edge %0d not seen", tag, k);
    end
  endtask

  task automatic run_xfer(input string tag, input logic [7:0] din, input logic [7:0] resp,
                          input logic [1:0] mode, input bit lb);
    logic [7:0] exp_rx;
    int         r0;
    bit         got;
    exp_rx    = lb ? din : resp;
    resp_word = resp;
    loopback  = lb;
    cur_cpha  = mode[0];
    CPOL      = mode[1];
    CPHA      = mode[0];
    tick();
    checks++;
    if (DCLK !== mode[1]) begin
      errors++;
      $display("FAIL %s idle_dclk: got %b required %b", tag, DCLK, mode[1]);
    end
    r0      = ready_cnt;
    data_in = din;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    data_in = 8'($urandom);
    CPHA    = ~mode[0];
    checks++;
    if (CS !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s cs_fall: got CS=%b busy=%b required CS=0 busy=1", tag, CS, busy);
    end
    wait_ready(tag, got);
    CPHA = mode[0];
    if (got) begin
      checks++;
      if (data_out !== exp_rx) begin
        errors++;
        $display("FAIL %s data_out: got %02h required %02h", tag, data_out, exp_rx);
      end
      checks++;
      if (mosi_word !== din) begin
        errors++;
        $display("FAIL %s mosi_word: got %02h required %02h", tag, mosi_word, din);
      end
      checks++;
      if (cs_low_cnt != CS_LOW) begin
        errors++;
        $display("FAIL %s cs_low: got %0d required %0d", tag, cs_low_cnt, CS_LOW);
      end
      checks++;
      if (edge_k != 2 * B) begin
        errors++;
        $display("FAIL %s edges: got %0d required %0d", tag, edge_k, 2 * B);
      end
      checks++;
      if (mosi_bad != 0) begin
        errors++;
        $display("FAIL %s mosi_stable: got %0d changes at sampling edges required 0", tag, mosi_bad);
      end
      checks++;
      if (busy !== 1'b0 || CS !== 1'b1 || ready_cnt - r0 != 1) begin
        errors++;
        $display("FAIL %s done_state: got busy=%b CS=%b pulses=%0d required 0 1 1", tag, busy, CS, ready_cnt - r0);
      end
      tick();
      checks++;
      if (data_ready !== 1'b0 || DCLK !== mode[1]) begin
        errors++;
        $display("FAIL %s after_done: got data_ready=%b DCLK=%b required 0 %b", tag, data_ready, DCLK, mode[1]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    tick();
    tick();
    checks++;
    if ({CS, DCLK, MOSI, busy, data_ready, data_out} !== {5'b10000, 8'h00}) begin
      errors++;
      $display("FAIL reset_values: got CS=%b DCLK=%b MOSI=%b busy=%b rdy=%b dout=%02h required 1 0 0 0 0 00",
               CS, DCLK, MOSI, busy, data_ready, data_out);
    end
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (CS !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_without_en: got CS=%b busy=%b required 1 0", CS, busy);
    end
    en = 1'b1;
    tick();
  endtask

  task automatic test_modes();
    run_xfer("mode0", 8'hA5, 8'h3C, MODE0, 1'b0);
    run_xfer("mode3_loop", 8'h81, 8'h00, MODE3, 1'b1);
    run_xfer("mode1", 8'h5A, 8'hC3, MODE1, 1'b0);
    run_xfer("mode2", 8'h5A, 8'hC3, MODE2, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_xfer("random", 8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)), 1'b0);
    end
  endtask

  task automatic test_abort();
    logic [7:0] prev;
    int         r0;
    bit         got;
    prev      = data_out;
    resp_word = 8'($urandom);
    loopback  = 1'b0;
    cur_cpha  = 1'b0;
    CPOL      = 1'b0;
    CPHA      = 1'b0;
    tick();
    r0      = ready_cnt;
    data_in = 8'($urandom);
    start   = 1'b1;
    tick();
    start   = 1'b0;
    wait_edge("abort", 7, got);
    en = 1'b0;
    tick();
    en = 1'b1;
    checks++;
    if (CS !== 1'b1 || busy !== 1'b0 || DCLK !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: got CS=%b busy=%b DCLK=%b required 1 0 0", CS, busy, DCLK);
    end
    for (int i = 0; i < 100; i++) tick();
    checks++;
    if (ready_cnt != r0 || data_out !== prev) begin
      errors++;
      $display("FAIL abort_no_ready: got pulses=%0d dout=%02h required 0 %02h", ready_cnt - r0, data_out, prev);
    end
    run_xfer("after_abort", 8'($urandom), 8'($urandom), MODE0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] r1, r2, d2;
    int         r0;
    bit         got;
    r1        = 8'($urandom);
    r2        = 8'($urandom);
    d2        = 8'($urandom);
    resp_word = r1;
    loopback  = 1'b0;
    cur_cpha  = 1'b0;
    CPOL      = 1'b0;
    CPHA      = 1'b0;
    tick();
    r0      = ready_cnt;
    data_in = 8'($urandom);
    start   = 1'b1;
    tick();
    start = 1'b0;
    got   = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (data_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
      start = (i % 3 == 0);
    end
    checks++;
    if (!got || ready_cnt - r0 != 1 || data_out !== r1) begin
      errors++;
      $display("FAIL b2b_first: got ready=%b pulses=%0d dout=%02h required 1 1 %02h", got, ready_cnt - r0, data_out, r1);
    end
    resp_word = r2;
    data_in   = d2;
    start     = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (CS !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart: got CS=%b busy=%b required 0 1", CS, busy);
    end
    wait_ready("b2b_second", got);
    checks++;
    if (data_out !== r2 || ready_cnt - r0 != 2) begin
      errors++;
      $display("FAIL b2b_second: got dout=%02h pulses=%0d required %02h 2", data_out, ready_cnt - r0, r2);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit got;
    resp_word = 8'($urandom);
    loopback  = 1'b0;
    cur_cpha  = 1'b1;
    CPOL      = 1'b1;
    CPHA      = 1'b1;
    tick();
    data_in = 8'($urandom);
    start   = 1'b1;
    tick();
    start = 1'b0;
    wait_edge("reset_mid", 5, got);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({CS, DCLK, busy, data_ready, data_out} !== {4'b1000, 8'h00}) begin
      errors++;
      $display("FAIL reset_mid: got CS=%b DCLK=%b busy=%b rdy=%b dout=%02h required 1 0 0 0 00",
               CS, DCLK, busy, data_ready, data_out);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_xfer("after_reset", 8'hFF, 8'($urandom), MODE0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_modes();
    test_random();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
